axil_reg_bank: RTL
==================

# axil_reg_bank

Native AXI4-Lite slave register bank that replaces the IP-based AXI-to-APB register path. It decodes a 64 KiB address segment into a parameterised set of read/write control registers and read-only status registers. It returns proper AXI error responses for unmapped and out-of-segment accesses, and emits per-register write pulses. It sits between the PS AXI-Lite interconnect and the RFSoC datapath control logic, all in the `axilite_clk` domain.

## Interface
- `ADDR_SEGMENT`, 16'h0000, required value of `awaddr/araddr[31:16]`.
- `N_RW`, 16, number of 32-bit RW registers (1..256).
- `N_RO`, 8, number of 32-bit RO status registers (0..256).
- `SELFCLR_MASK`, {N_RW{1'b0}}, bit i=1 makes RW register i self-clearing.

- `axilite_clk`  in  1  bank clock.
- `axilite_rst`  in  1  asynchronous, active-high reset.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `rw_regs`  out  N_RW*32  RW register contents; register i is at bits [32i+31:32i].
- `wr_pulse`  out  N_RW  one-cycle strobe per RW register on committed write.
- `ro_regs`  in  N_RO*32  status inputs, synchronous to `axilite_clk`.

## Operation
- Index is `addr[15:2]`. `addr[1:0]` is ignored.
  - Index 0..N_RW-1 maps to RW register.
  - Index N_RW..N_RW+N_RO-1 maps to RO register (index−N_RW).
- Response codes:
  - Segment mismatch: DECERR (2'b11).
  - In-segment, unmapped index: SLVERR (2'b10).
  - Write to an RO index: SLVERR, no effect.
  - Otherwise: OKAY (2'b00).
  - Errored reads return `rdata`=0.
- Write FSM states: W_IDLE and W_RESP.
  - AW and W are accepted independently in W_IDLE, in either order or in the same cycle, and are latched into hold flags.
  - Once both are held, the commit happens on the next edge:
    - Bytes with `wstrb` set are written.
    - `wr_pulse[i]` is high for exactly one cycle.
    - `bvalid` asserts and the FSM moves to W_RESP.
  - A commit with `wstrb`=0 still returns OKAY and pulses `wr_pulse[i]`; register contents are unchanged.
  - In W_RESP, `bvalid`/`bresp` hold until `bready`, then the FSM returns to W_IDLE.
- Read FSM states: R_IDLE and R_DATA.
  - On the AR handshake, data is sampled into `rdata`/`rresp` (`ro_regs` is sampled at that edge) and `rvalid` asserts.
  - In R_DATA, `rvalid`/`rdata` hold until `rready`.
- The read and write FSMs are fully independent and may run concurrently.
- Self-clear: RW register i with `SELFCLR_MASK[i]`=1 holds the written value for one cycle, then returns to 0.

## Timing
- Ready signals:
  - `awready` = W_IDLE & !aw_held.
  - `wready` = W_IDLE & !w_held.
  - `arready` = R_IDLE.
- Write latency: last of AW/W handshakes at edge E; `rw_regs`, `wr_pulse`, `bvalid` change at edge E+1.
- Read latency: AR handshake at edge E; `rvalid`/`rdata` valid after edge E.
- Back-to-back throughput:
  - Read: one per 2 cycles with `rready` held high.
  - Write: one per 3 cycles with `bready` held high.
- Same-address read/write overlap: the read returns the pre-write value if its AR edge is ≤ the commit edge, and the new value otherwise.
- Reset (asynchronous, any point including mid-transaction):
  - FSMs return to W_IDLE/R_IDLE and hold flags clear.
  - `rw_regs`=0, `wr_pulse`=0, `bvalid`=0, `rvalid`=0, `rdata`=0, `bresp`=0, `rresp`=0.
  - `awready`=`wready`=`arready`=1.
  - An interrupted transaction is dropped with no response.

## Configuration
- `AXIL_REG_BANK_SELFCLR_EN`
  - Defined: `SELFCLR_MASK` is honoured as described above.
  - Undefined: `SELFCLR_MASK` is ignored; all RW registers hold their value until the next write or reset, and no self-clear logic is synthesised.

## Test plan
- Reset, then write 0xDEADBEEF with `wstrb`=4'hF to offset 0x0004 with AW and W in the same cycle:
  - `rw_regs[63:32]`=0xDEADBEEF and `wr_pulse`=16'h0002 for one cycle at E+1.
  - `bresp`=OKAY.
  - Read-back of 0x0004 returns 0xDEADBEEF.
- W presented 3 cycles before AW, `wstrb`=4'b0101, data 0x11223344, to offset 0x0000, where register 0 previously held 0xAABBCCDD:
  - Register 0 becomes 0xAA22CC44.
  - `awready` stays high while `wready` is low.
- `ro_regs` word 0 = 0x12345678 with N_RW=16, read offset 0x0040:
  - `rdata`=0x12345678, `rresp`=OKAY.
  - A write to 0x0040 returns SLVERR and changes nothing.
- Read with `araddr`=0x0001_0000 when ADDR_SEGMENT=0 returns DECERR with `rdata`=0.
- Read offset 0x0060 (index 24 = N_RW+N_RO) returns SLVERR with `rdata`=0.
- `SELFCLR_MASK`=16'h0008 with the macro defined: write 0x1 to 0x000C; register 3 reads 1 for one cycle, then 0.
  - With the macro undefined, register 3 stays at 1.
- Assert `axilite_rst` while `bvalid`=1: `bvalid` drops immediately and the next write completes normally.

Source files
------------

// File: rtl/axil_reg_bank.sv
//==============================================================================
// Module  : axil_reg_bank
// Brief   : AXI4-Lite slave bank of RW control and RO status registers with
//           DECERR/SLVERR decode and per-register write pulses.
//           Optional self-clear support enabled by AXIL_REG_BANK_SELFCLR_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module axil_reg_bank #(
    parameter logic [15:0] ADDR_SEGMENT = 16'h0000,
    parameter int          N_RW         = 16,
    parameter int          N_RO         = 8,
    parameter logic [N_RW-1:0] SELFCLR_MASK = '0,
    localparam int         RO_W         = (N_RO > 0) ? N_RO : 1
) (
    input  logic                 axilite_clk,
    input  logic                 axilite_rst,
    input  logic [31:0]          awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [31:0]          araddr,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [N_RW*32-1:0]   rw_regs,
    output logic [N_RW-1:0]      wr_pulse,
    input  logic [RO_W*32-1:0]   ro_regs
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    wstate_t      r_wstate, w_wstate_nxt;
    rstate_t      r_rstate, w_rstate_nxt;

    logic         r_aw_held, r_w_held;
    logic [31:2]  r_awaddr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_wstrb;
    logic [31:0]  r_rw [N_RW];
    logic [N_RW-1:0] r_wr_pulse;
    logic         r_bvalid, r_rvalid;
    logic [1:0]   r_bresp, r_rresp;
    logic [31:0]  r_rdata;

    logic         w_commit, w_wr_rw, w_ar_hs;
    logic [31:0]  w_wr_idx, w_rd_idx, w_rd_data;
    logic [1:0]   w_wr_resp, w_rd_resp;
    logic         w_unused_addr;

    assign w_unused_addr = ^{awaddr[1:0], araddr[1:0]};

    assign awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign arready = (r_rstate == R_IDLE);
    assign w_commit = (r_wstate == W_IDLE) && r_aw_held && r_w_held;
    assign w_ar_hs  = arvalid && arready;

    assign w_wr_idx = {18'd0, r_awaddr[15:2]};
    assign w_rd_idx = {18'd0, araddr[15:2]};

    // Write decode works on the latched address so AW may precede W.
    always_comb begin
        w_wr_rw   = 1'b0;
        w_wr_resp = c_RESP_OKAY;
        if (r_awaddr[31:16] != ADDR_SEGMENT)
            w_wr_resp = c_RESP_DECERR;
        else if (w_wr_idx >= 32'(N_RW))
            w_wr_resp = c_RESP_SLVERR;
        else
            w_wr_rw = 1'b1;
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_RESP_OKAY;
        if (araddr[31:16] != ADDR_SEGMENT) begin
            w_rd_resp = c_RESP_DECERR;
        end else if (w_rd_idx >= 32'(N_RW + N_RO)) begin
            w_rd_resp = c_RESP_SLVERR;
        end else begin
            for (int i = 0; i < N_RW; i++)
                if (w_rd_idx == 32'(i)) w_rd_data = r_rw[i];
            for (int j = 0; j < N_RO; j++)
                if (w_rd_idx == 32'(N_RW + j)) w_rd_data = ro_regs[32*j +: 32];
        end
    end

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (bready)   w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (rready)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else begin
                if (awvalid && awready) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= awaddr[31:2];
                end
                if (wvalid && wready) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= wdata;
                    r_wstrb  <= wstrb;
                end
                if (r_bvalid && bready) r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            for (int i = 0; i < N_RW; i++) r_rw[i] <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
`ifdef AXIL_REG_BANK_SELFCLR_EN
            // Self-clearing registers fall back to zero unless rewritten now.
            for (int i = 0; i < N_RW; i++)
                if (SELFCLR_MASK[i]) r_rw[i] <= '0;
`endif
            if (w_commit && w_wr_rw) begin
                for (int i = 0; i < N_RW; i++) begin
                    if (w_wr_idx == 32'(i)) begin
                        r_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (r_wstrb[b]) r_rw[i][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
            assign rw_regs[32*g +: 32] = r_rw[g];
        end
    endgenerate

    assign wr_pulse = r_wr_pulse;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;

endmodule

`default_nettype wire
